// File: rtl/fpga_io_pkg.sv
// Shared encodings for the FPGA GPIO bridge: LED drive modes and debounce FSM states.
package fpga_io_pkg;

    typedef enum logic [1:0] {
        LED_DIRECT = 2'b00,
        LED_PWM    = 2'b01,
        LED_BLINK  = 2'b10,
        LED_OFF    = 2'b11
    } led_mode_e;

    typedef enum logic {
        DB_STABLE  = 1'b0,
        DB_PENDING = 1'b1
    } db_state_e;

    // The user button always crosses into the clock domain through two flops.
    localparam int BTN_SYNC_STAGES = 2;

endpackage

// File: rtl/fpga_gpio_bridge_if.sv
// Board-side and core-side signal bundle of the GPIO bridge.
// slave is the bridge's view, master is the view of whoever drives the bridge.
interface fpga_gpio_bridge_if #(
    parameter int NUM_IO = 20,
    parameter int PWM_W  = 8
);
    logic [NUM_IO-1:0] core_io_out;
    logic [NUM_IO-1:0] core_io_oeb;
    logic [NUM_IO-1:0] core_io_in;
    logic [NUM_IO-1:0] pad_in;
    logic [NUM_IO-1:0] pad_out;
    logic [NUM_IO-1:0] pad_oe;
    logic              btn_i;
    logic              btn_o;
    logic              btn_rise;
    logic              led_i;
    logic [1:0]        led_mode;
    logic [PWM_W-1:0]  duty_r;
    logic [PWM_W-1:0]  duty_g;
    logic [PWM_W-1:0]  duty_b;
    logic              rgb_led_r;
    logic              rgb_led_g;
    logic              rgb_led_b;

    modport slave (
        input  core_io_out, core_io_oeb, pad_in, btn_i, led_i, led_mode,
               duty_r, duty_g, duty_b,
        output core_io_in, pad_out, pad_oe, btn_o, btn_rise,
               rgb_led_r, rgb_led_g, rgb_led_b
    );

    modport master (
        output core_io_out, core_io_oeb, pad_in, btn_i, led_i, led_mode,
               duty_r, duty_g, duty_b,
        input  core_io_in, pad_out, pad_oe, btn_o, btn_rise,
               rgb_led_r, rgb_led_g, rgb_led_b
    );

endinterface

// File: rtl/fpga_debounce.sv
// Button synchroniser plus debounce FSM. A change on the synchronised button is
// accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement with
// the current debounced level; any earlier return to that level discards it.
module fpga_debounce
    import fpga_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_btn,
    output logic o_rise
);
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic [BTN_SYNC_STAGES-1:0] r_btn_sync;
    db_state_e                  r_state;
    db_state_e                  w_state_n;
    logic [CNT_W-1:0]           r_cnt;
    logic [CNT_W-1:0]           w_cnt_n;
    logic [CNT_W-1:0]           w_cnt_inc;
    logic                       r_btn;
    logic                       w_btn_n;
    logic                       r_rise;
    logic                       w_rise_n;
    logic                       w_btn_s;

    assign w_btn_s   = r_btn_sync[BTN_SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign o_btn     = r_btn;
    assign o_rise    = r_rise;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_sync <= '0;
        end else begin
            r_btn_sync <= {r_btn_sync[BTN_SYNC_STAGES-2:0], i_btn};
        end
    end

    // FSM state, stability counter and debounced level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
            r_btn   <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_btn   <= w_btn_n;
            r_rise  <= w_rise_n;
        end
    end

    // Next-state logic; the counter stops at CNT_DONE so it can never wrap.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_btn_n   = r_btn;
        w_rise_n  = 1'b0;
        case (r_state)
            DB_STABLE: begin
                if (w_btn_s != r_btn) begin
                    w_state_n = DB_PENDING;
                    w_cnt_n   = CNT_W'(1);
                end
            end
            DB_PENDING: begin
                if (w_btn_s == r_btn) begin
                    w_state_n = DB_STABLE;
                end else if (w_cnt_inc == CNT_DONE) begin
                    w_state_n = DB_STABLE;
                    w_cnt_n   = CNT_DONE;
                    w_btn_n   = ~r_btn;
                    w_rise_n  = ~r_btn;
                end else begin
                    w_cnt_n   = w_cnt_inc;
                end
            end
            default: w_state_n = DB_STABLE;
        endcase
    end

endmodule

// File: rtl/fpga_gpio_bridge.sv
// Bridges board GPIO pads, a user button and an RGB LED to an emulated
// user-project IO bus. Pad outputs are registered, pad inputs synchronised,
// the button debounced and the LEDs driven directly, by PWM or by blinking.
module fpga_gpio_bridge
    import fpga_io_pkg::*;
#(
    parameter int NUM_IO          = 20,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int PWM_W           = 8,
    parameter int BLINK_DIV       = 4194304
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    fpga_gpio_bridge_if.slave bus
);
    localparam int                 BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [NUM_IO-1:0]  r_pad_out;
    logic [NUM_IO-1:0]  r_pad_oe;
    logic [NUM_IO-1:0]  r_pad_sync [SYNC_STAGES];
    logic [PWM_W-1:0]   r_pwm_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_phase;
    logic               r_led_r;
    logic               r_led_g;
    logic               r_led_b;
    logic               w_led_r;
    logic               w_led_g;
    logic               w_led_b;
    logic               w_btn_o;
    logic               w_btn_rise;

    assign bus.pad_out    = r_pad_out;
    assign bus.pad_oe     = r_pad_oe;
    assign bus.core_io_in = r_pad_sync[SYNC_STAGES-1];
    assign bus.btn_o      = w_btn_o;
    assign bus.btn_rise   = w_btn_rise;
    assign bus.rgb_led_r  = r_led_r;
    assign bus.rgb_led_g  = r_led_g;
    assign bus.rgb_led_b  = r_led_b;

    // Register core output data; active-low core enable becomes active-high pad drive.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_pad_out <= '0;
            r_pad_oe  <= '0;
        end else begin
            r_pad_out <= bus.core_io_out;
            r_pad_oe  <= ~bus.core_io_oeb;
        end
    end

    // Multi-flop synchroniser from the pads toward the core.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_pad_sync[i] <= '0;
        end else begin
            r_pad_sync[0] <= bus.pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_pad_sync[i] <= r_pad_sync[i-1];
        end
    end

    fpga_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .i_btn  (bus.btn_i),
        .o_btn  (w_btn_o),
        .o_rise (w_btn_rise)
    );

    // Free-running PWM and blink timebases; unaffected by LED mode changes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Select the LED drive for the current mode.
    always_comb begin
        w_led_r = 1'b0;
        w_led_g = 1'b0;
        w_led_b = 1'b0;
        case (led_mode_e'(bus.led_mode))
            LED_DIRECT: begin
                w_led_r = bus.led_i;
                w_led_g = bus.led_i;
                w_led_b = bus.led_i;
            end
            LED_PWM: begin
                w_led_r = bus.led_i & (r_pwm_cnt < bus.duty_r);
                w_led_g = bus.led_i & (r_pwm_cnt < bus.duty_g);
                w_led_b = bus.led_i & (r_pwm_cnt < bus.duty_b);
            end
            LED_BLINK: begin
                w_led_r = bus.led_i & r_blink_phase;
                w_led_g = bus.led_i & r_blink_phase;
                w_led_b = bus.led_i & r_blink_phase;
            end
            default: ;
        endcase
    end

    // Register the LED drives so the board sees glitch-free outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_led_r <= 1'b0;
            r_led_g <= 1'b0;
            r_led_b <= 1'b0;
        end else begin
            r_led_r <= w_led_r;
            r_led_g <= w_led_g;
            r_led_b <= w_led_b;
        end
    end

endmodule

// File: tb/tb_fpga_gpio_bridge.sv
// Bench for fpga_gpio_bridge: random stimulus checked every cycle against a
// behavioural model, plus directed scenarios with hand-computed expectations.
module tb_fpga_gpio_bridge;
    localparam int NUM_IO      = 20;
    localparam int SYNC_STAGES = 2;
    localparam int DEB         = 8;
    localparam int PWM_W       = 4;
    localparam int BLINK_DIV   = 3;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    fpga_gpio_bridge_if #(.NUM_IO(NUM_IO), .PWM_W(PWM_W)) bus();

    fpga_gpio_bridge #(
        .NUM_IO          (NUM_IO),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEB),
        .PWM_W           (PWM_W),
        .BLINK_DIV       (BLINK_DIV)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NUM_IO-1:0] m_pad_out, m_pad_oe, m_cin;
    logic [NUM_IO-1:0] m_pq[$];
    logic              m_bq[$];
    logic              m_bo, m_rise, m_s, m_ph;
    logic [2:0]        m_rgb;
    int                m_run, m_k, m_pwm;

    // Model: pads delayed by one edge, pad inputs by SYNC_STAGES edges, button
    // accepted after DEB consecutive disagreeing samples, LEDs from edge count.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pad_out = '0;
            m_pad_oe  = '0;
            m_cin     = '0;
            m_pq.delete();
            m_bq.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_pq.push_back('0);
            m_bq.push_back(1'b0);
            m_bq.push_back(1'b0);
            m_bo   = 1'b0;
            m_rise = 1'b0;
            m_run  = 0;
            m_k    = 0;
            m_rgb  = 3'b000;
        end else begin
            m_pad_out = bus.core_io_out;
            m_pad_oe  = ~bus.core_io_oeb;
            void'(m_pq.pop_front());
            m_pq.push_back(bus.pad_in);
            m_cin = m_pq[0];
            m_s = m_bq[0];
            void'(m_bq.pop_front());
            m_bq.push_back(bus.btn_i);
            m_rise = 1'b0;
            if (m_s != m_bo) m_run++;
            else m_run = 0;
            if (m_run == DEB) begin
                m_bo   = ~m_bo;
                m_run  = 0;
                m_rise = m_bo;
            end
            m_pwm = m_k % (1 << PWM_W);
            m_ph  = ((m_k / BLINK_DIV) % 2) == 1;
            case (bus.led_mode)
                2'b00:   m_rgb = {3{bus.led_i}};
                2'b01:   m_rgb = {bus.led_i && (int'(bus.duty_r) > m_pwm),
                                  bus.led_i && (int'(bus.duty_g) > m_pwm),
                                  bus.led_i && (int'(bus.duty_b) > m_pwm)};
                2'b10:   m_rgb = {3{bus.led_i & m_ph}};
                default: m_rgb = 3'b000;
            endcase
            m_k++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("pad_out",    32'(bus.pad_out),    32'(m_pad_out));
            chk("pad_oe",     32'(bus.pad_oe),     32'(m_pad_oe));
            chk("core_io_in", 32'(bus.core_io_in), 32'(m_cin));
            chk("btn_o",      32'(bus.btn_o),      32'(m_bo));
            chk("btn_rise",   32'(bus.btn_rise),   32'(m_rise));
            chk("rgb",        32'({bus.rgb_led_r, bus.rgb_led_g, bus.rgb_led_b}), 32'(m_rgb));
        end
    end

    // ---------------- stimulus and directed checks ----------------
    int   hold;
    int   edge_hit, pulses, seen, hr, hg, hb, bad, trans;
    logic v [15];

    task automatic wait_btn_rise(input string tag);
        edge_hit = 0;
        pulses   = 0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); #1;
            if (bus.btn_rise) pulses++;
            if (bus.btn_o && edge_hit == 0) edge_hit = e;
        end
        chk({tag, "_rise_edge"},   32'(edge_hit), 32'(SYNC_STAGES + DEB));
        chk({tag, "_rise_pulses"}, 32'(pulses),   32'd1);
        chk({tag, "_btn_o_held"},  32'(bus.btn_o), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        bus.core_io_out = '0;
        bus.core_io_oeb = '1;
        bus.pad_in      = '0;
        bus.btn_i       = 1'b0;
        bus.led_i       = 1'b0;
        bus.led_mode    = 2'b00;
        bus.duty_r      = '0;
        bus.duty_g      = '0;
        bus.duty_b      = '0;
        bus.core_io_out = NUM_IO'(20'h12345);
        bus.core_io_oeb = '0;
        bus.led_i       = 1'b1;
        repeat (3) @(negedge clk);

        // Outputs held at zero while reset is active, whatever the inputs.
        chk("rst_pad_oe",  32'(bus.pad_oe),     32'd0);
        chk("rst_pad_out", 32'(bus.pad_out),    32'd0);
        chk("rst_cin",     32'(bus.core_io_in), 32'd0);
        chk("rst_btn_o",   32'(bus.btn_o),      32'd0);
        chk("rst_rise",    32'(bus.btn_rise),   32'd0);
        chk("rst_rgb",     32'({bus.rgb_led_r, bus.rgb_led_g, bus.rgb_led_b}), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Random traffic on every input.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.core_io_out = NUM_IO'($urandom);
            bus.core_io_oeb = NUM_IO'($urandom);
            bus.pad_in      = NUM_IO'($urandom);
            if (hold == 0) begin
                bus.btn_i = ~bus.btn_i;
                hold = int'($urandom_range(1, 14));
            end else begin
                hold--;
            end
            if (c % 25 == 0) bus.led_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) bus.led_i = ~bus.led_i;
            if ($urandom_range(0, 7) == 0) begin
                bus.duty_r = PWM_W'($urandom);
                bus.duty_g = PWM_W'($urandom);
                bus.duty_b = PWM_W'($urandom);
            end
        end

        // Pad registering and input synchroniser latency.
        @(negedge clk);
        bus.core_io_oeb = '1;
        bus.core_io_out = '0;
        bus.pad_in      = '0;
        repeat (3) @(negedge clk);
        bus.core_io_oeb = '0;
        bus.core_io_out = NUM_IO'(20'hA5A5A);
        bus.pad_in      = NUM_IO'(20'h0F0F0);
        @(posedge clk); #1;
        chk("pad_oe_lat1",  32'(bus.pad_oe),     32'hFFFFF);
        chk("pad_out_lat1", 32'(bus.pad_out),    32'hA5A5A);
        chk("cin_lat1",     32'(bus.core_io_in), 32'h00000);
        @(posedge clk); #1;
        chk("cin_lat2",     32'(bus.core_io_in), 32'h0F0F0);

        // Button: a 5-cycle bounce is rejected.
        @(negedge clk);
        bus.btn_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("bounce_start_btn_o", 32'(bus.btn_o), 32'd0);
        bus.btn_i = 1'b1;
        repeat (5) @(negedge clk);
        bus.btn_i = 1'b0;
        seen = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            if (bus.btn_o || bus.btn_rise) seen++;
        end
        chk("bounce_rejected", 32'(seen), 32'd0);

        // Button held: accepted after sync + DEB edges with a single pulse.
        @(negedge clk);
        bus.btn_i = 1'b1;
        wait_btn_rise("hold");

        // Falling edge gives no pulse.
        @(negedge clk);
        bus.btn_i = 1'b0;
        pulses = 0;
        for (int e = 0; e < 14; e++) begin
            @(posedge clk); #1;
            if (bus.btn_rise) pulses++;
        end
        chk("fall_no_pulse", 32'(pulses), 32'd0);
        chk("fall_btn_o",    32'(bus.btn_o), 32'd0);

        // PWM duty over one full period.
        @(negedge clk);
        bus.led_mode = 2'b01;
        bus.led_i    = 1'b1;
        bus.duty_r   = PWM_W'(0);
        bus.duty_g   = PWM_W'(4);
        bus.duty_b   = PWM_W'(15);
        @(posedge clk);
        hr = 0; hg = 0; hb = 0;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            hr += int'(bus.rgb_led_r);
            hg += int'(bus.rgb_led_g);
            hb += int'(bus.rgb_led_b);
        end
        chk("pwm_r_high", 32'(hr), 32'd0);
        chk("pwm_g_high", 32'(hg), 32'd4);
        chk("pwm_b_high", 32'(hb), 32'd15);

        // Blink: LEDs invert every BLINK_DIV cycles.
        @(negedge clk);
        bus.led_mode = 2'b10;
        @(posedge clk);
        bad = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk); #1;
            v[e] = bus.rgb_led_r;
            if (bus.rgb_led_g != v[e] || bus.rgb_led_b != v[e]) bad++;
        end
        trans = 0;
        for (int e = 0; e < 12; e++) if (v[e + 3] == v[e]) bad++;
        for (int e = 1; e < 15; e++) if (v[e] != v[e - 1]) trans++;
        chk("blink_period", 32'(bad), 32'd0);
        chk("blink_trans",  32'(trans >= 4 && trans <= 5), 32'd1);
        @(negedge clk);
        bus.led_i = 1'b0;
        @(posedge clk); #1;
        chk("blink_led_off", 32'({bus.rgb_led_r, bus.rgb_led_g, bus.rgb_led_b}), 32'd0);

        // Asynchronous reset mid-debounce with pads driven.
        @(negedge clk);
        bus.led_mode    = 2'b00;
        bus.led_i       = 1'b1;
        bus.core_io_oeb = '0;
        bus.core_io_out = NUM_IO'(20'h5A5A5);
        bus.pad_in      = NUM_IO'(20'hFFFFF);
        bus.btn_i       = 1'b1;
        repeat (6) @(negedge clk);
        chk("prerst_pad_oe", 32'(bus.pad_oe), 32'hFFFFF);
        chk("prerst_rgb",    32'({bus.rgb_led_r, bus.rgb_led_g, bus.rgb_led_b}), 32'h7);
        chk("prerst_btn_o",  32'(bus.btn_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pad_oe",  32'(bus.pad_oe),     32'd0);
        chk("arst_pad_out", 32'(bus.pad_out),    32'd0);
        chk("arst_cin",     32'(bus.core_io_in), 32'd0);
        chk("arst_btn_o",   32'(bus.btn_o),      32'd0);
        chk("arst_rise",    32'(bus.btn_rise),   32'd0);
        chk("arst_rgb",     32'({bus.rgb_led_r, bus.rgb_led_g, bus.rgb_led_b}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_btn_rise("post_rst");

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpga_gpio_bridge.md
FPGA_GPIO_BRIDGE -- requirements
Module: fpga_gpio_bridge

Interface
REQ-001 Parameter NUM_IO, default 20, number of bidirectional board GPIO channels bridged to the emulated user-project IO bus.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, input synchroniser depth.
REQ-003 Parameter DEBOUNCE_CYCLES, default 65536, minimum 2, consecutive stable cycles required to accept a button change.
REQ-004 Parameter PWM_W, default 8, LED PWM counter and duty width.
REQ-005 Parameter BLINK_DIV, default 2^22, minimum 1, cycles per LED blink half-period.
REQ-006 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-007 wb_rst_i  in  1  asynchronous, active-high reset.
REQ-008 core_io_out  in  NUM_IO  output data from emulated core.
REQ-009 core_io_oeb  in  NUM_IO  output enable from core, active low.
REQ-010 core_io_in  out  NUM_IO  synchronised pad input to core.
REQ-011 pad_in  in  NUM_IO  raw pad input from tristate buffers.
REQ-012 pad_out  out  NUM_IO  data to tristate buffers.
REQ-013 pad_oe  out  NUM_IO  tristate drive enable, active high.
REQ-014 btn_i  in  1  raw asynchronous user button.
REQ-015 btn_o  out  1  debounced button level to core.
REQ-016 btn_rise  out  1  one-cycle pulse on btn_o 0->1.
REQ-017 led_i  in  1  LED request from core.
REQ-018 led_mode  in  2  00 direct, 01 PWM, 10 blink, 11 off.
REQ-019 duty_r, duty_g, duty_b  in  PWM_W each  per-colour PWM duty.
REQ-020 rgb_led_r, rgb_led_g, rgb_led_b  out  1 each  registered LED drives.

Function
REQ-021 pad_out and pad_oe SHALL be registered: pad_out = core_io_out, pad_oe = ~core_io_oeb, latency 1 cycle.
REQ-022 core_io_in[i] SHALL be pad_in[i] through SYNC_STAGES flops, latency exactly SYNC_STAGES cycles, no combinational path.
REQ-023 btn_i SHALL pass a 2-flop synchroniser before the debounce FSM.
REQ-024 Debounce FSM states: STABLE, PENDING; STABLE->PENDING when synced btn != btn_o, counter cleared to 1.
REQ-025 In PENDING: synced btn == btn_o -> STABLE (bounce rejected, btn_o unchanged); else counter increments; when counter reaches DEBOUNCE_CYCLES, btn_o toggles and FSM -> STABLE.
REQ-026 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); counter SHALL never wrap.
REQ-027 btn_rise SHALL assert for exactly the cycle in which btn_o becomes 1; falling edges produce no pulse.
REQ-028 Free-running PWM counter PWM_W bits, wraps 2^PWM_W-1 -> 0.
REQ-029 Mode 00: each LED = led_i, registered, 1-cycle latency.
REQ-030 Mode 01: LED c = led_i AND (pwm_cnt < duty_c); duty 0 -> always off; duty all-ones -> off one cycle per period.
REQ-031 Mode 10: blink counter toggles a phase bit every BLINK_DIV cycles; all LEDs = led_i AND phase.
REQ-032 Mode 11: all LEDs 0.
REQ-033 led_mode change SHALL take effect on the next registered LED update; PWM and blink counters SHALL not reset on mode change.

Reset
REQ-034 On wb_rst_i assertion, immediately: pad_oe all 0 (all pads high-impedance), pad_out 0, core_io_in 0, all synchroniser flops 0.
REQ-035 Reset: btn_o 0, btn_rise 0, FSM STABLE, debounce counter 0, PWM counter 0, blink counter and phase 0, all LEDs 0.
REQ-036 Reset mid-debounce SHALL abandon the pending change; after release a held button requires a full DEBOUNCE_CYCLES again.

Structure
REQ-037 Mode encodings (LED_DIRECT, LED_PWM, LED_BLINK, LED_OFF) and FSM state encodings SHALL live in shared package fpga_io_pkg.
REQ-038 Debounce logic SHALL be one sub-module, fpga_debounce, parametrised by DEBOUNCE_CYCLES.

Verification
REQ-039 NUM_IO=20: core_io_oeb=0, core_io_out=20'hA5A5A -> pad_oe=all 1, pad_out=20'hA5A5A one cycle later; pad_in=20'h0F0F0 -> core_io_in=20'h0F0F0 exactly 2 cycles later.
REQ-040 DEBOUNCE_CYCLES=8: btn_i high 5 cycles then low -> btn_o stays 0; btn_i held high -> btn_o 1 after sync+8 cycles, btn_rise single-cycle.
REQ-041 PWM_W=4, mode 01, led_i=1, duty_r=0, duty_g=4, duty_b=15 -> over 16 cycles r high 0, g high 4, b high 15 cycles.
REQ-042 BLINK_DIV=3, mode 10, led_i=1 -> LEDs toggle every 3 cycles; led_i=0 -> LEDs 0.
REQ-043 Assert wb_rst_i during PENDING and with pad_oe=1 -> pad_oe=0 and all outputs 0 without a clock edge; after release, held button needs full 8 cycles.
